// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU constants: next-PC select encodings and the default reset fetch address.
// The controller and the fetch unit both import this package.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection. Branch and jump targets are relative to the
// instruction in D, because the redirect lands after its delay slot.
module npc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] imm_ext,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;

    assign seq_pc = f_pc + 32'd4;
    // The top two offset bits fall off; the sum wraps modulo 2^32.
    assign br_off = {imm_ext[29:0], 2'b00};

    always_comb begin
        npc = seq_pc;
        case (npc_op_e'(npc_op))
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = br_taken ? (d_pc + 32'd4 + br_off) : seq_pc;
            NPC_J:   npc = {d_pc[31:28], instr_index, 2'b00};
            NPC_JR:  npc = rs_data;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register plus IF/ID pipeline register, with hazard stall and a sticky
// misaligned-register-target flag. IM is external and read at F_pc.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] imm_ext,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic [31:0] im_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc8,
    output logic        adr_err
);

    logic [31:0] npc;

    npc_calc u_npc_calc (
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .imm_ext     (imm_ext),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .f_pc        (F_pc),
        .d_pc        (D_pc),
        .npc         (npc)
    );

    // No flush: the delay-slot instruction always moves into D alongside the redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc    <= RESET_PC;
            D_pc    <= RESET_PC;
            D_instr <= 32'h0;
            adr_err <= 1'b0;
        end else if (!stall) begin
            F_pc    <= npc;
            D_pc    <= F_pc;
            D_instr <= im_instr;
            if (npc_op_e'(npc_op) == NPC_JR && misaligned(rs_data))
                adr_err <= 1'b1;
        end
    end

    assign D_pc8 = D_pc + 32'd8;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] imm_ext;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] im_instr;
    logic [31:0] F_pc, D_pc, D_instr, D_pc8;
    logic        adr_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference architectural state
    logic [31:0] m_f, m_d, m_i;
    logic        m_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign im_instr = instr_at(F_pc);

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .imm_ext     (imm_ext),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .im_instr    (im_instr),
        .F_pc        (F_pc),
        .D_pc        (D_pc),
        .D_instr     (D_instr),
        .D_pc8       (D_pc8),
        .adr_err     (adr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs, clock the DUT, compare.
    task automatic cycle(input string tag);
        logic [31:0] tgt;
        if (reset) begin
            m_f = RST_PC; m_d = RST_PC; m_i = 32'h0; m_e = 1'b0;
        end else if (!stall) begin
            case (npc_op)
                2'd1:    tgt = br_taken ? m_d + 32'd4 + imm_ext * 32'd4 : m_f + 32'd4;
                2'd2:    tgt = {m_d[31:28], instr_index, 2'b00};
                2'd3:    tgt = rs_data;
                default: tgt = m_f + 32'd4;
            endcase
            if (npc_op == 2'd3 && rs_data % 4 != 0) m_e = 1'b1;
            m_i = instr_at(m_f);
            m_d = m_f;
            m_f = tgt;
        end
        @(posedge clk);
        #1;
        chk({tag, ".F_pc"},    F_pc,    m_f);
        chk({tag, ".D_pc"},    D_pc,    m_d);
        chk({tag, ".D_instr"}, D_instr, m_i);
        chk({tag, ".D_pc8"},   D_pc8,   m_d + 32'd8);
        chk({tag, ".adr_err"}, {31'b0, adr_err}, {31'b0, m_e});
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] op, input logic bt);
        reset = r; stall = s; npc_op = op; br_taken = bt;
    endtask

    initial begin
        logic [15:0] r16;
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        imm_ext = 32'h0; instr_index = 26'h0; rs_data = 32'h0;
        m_f = 32'hx; m_d = 32'hx; m_i = 32'hx; m_e = 1'bx;

        // Reset then free run
        cycle("rst0");
        cycle("rst1");
        chk("rst.D_instr_nop", D_instr, 32'h0);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        cycle("seq");
        chk("seq.F_pc_3004", F_pc, 32'h3004);
        chk("seq.D_pc_3000", D_pc, 32'h3000);
        cycle("seq");
        chk("seq.F_pc_3008", F_pc, 32'h3008);

        // Taken backward branch with D_pc=0x3010
        repeat (3) cycle("seq");
        chk("br.pre_D_pc", D_pc, 32'h3010);
        drive(1'b0, 1'b0, 2'd1, 1'b1); imm_ext = 32'hFFFF_FFFC;
        cycle("br_taken");
        chk("br.F_pc_3004", F_pc, 32'h3004);
        chk("br.delay_slot", D_instr, instr_at(32'h3014));

        // Not-taken branch then jump from D_pc=0x3020
        drive(1'b1, 1'b0, 2'd0, 1'b0); cycle("rst");
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (8) cycle("seq");
        drive(1'b0, 1'b0, 2'd1, 1'b0); imm_ext = 32'h0000_0040;
        cycle("br_nt");
        chk("br_nt.F_pc", F_pc, 32'h3024);
        drive(1'b0, 1'b0, 2'd2, 1'b1); instr_index = 26'h0000_C40;
        cycle("jump");
        chk("jump.F_pc_3100", F_pc, 32'h0000_3100);

        // Stall while a register redirect is presented
        drive(1'b0, 1'b1, 2'd3, 1'b0); rs_data = 32'h3200;
        repeat (3) cycle("stall_jr");
        chk("stall.F_pc_held", F_pc, 32'h3100);
        drive(1'b0, 1'b0, 2'd3, 1'b0);
        cycle("jr");
        chk("jr.F_pc_3200", F_pc, 32'h3200);

        // Misaligned register target; stalled misaligned jr must not set the flag
        drive(1'b1, 1'b0, 2'd0, 1'b0); cycle("rst");
        drive(1'b0, 1'b1, 2'd3, 1'b0); rs_data = 32'h3202;
        cycle("stall_misal");
        chk("stall_misal.no_err", {31'b0, adr_err}, 32'h0);
        drive(1'b0, 1'b0, 2'd3, 1'b0);
        cycle("misal_jr");
        chk("misal.F_pc", F_pc, 32'h3202);
        chk("misal.adr_err", {31'b0, adr_err}, 32'h1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (3) cycle("sticky");
        chk("sticky.adr_err", {31'b0, adr_err}, 32'h1);

        // Reset beats stall and a pending taken branch
        drive(1'b1, 1'b1, 2'd1, 1'b1); imm_ext = 32'h0000_0100;
        cycle("rst_stall");
        chk("rst_stall.F_pc", F_pc, 32'h3000);
        chk("rst_stall.D_instr", D_instr, 32'h0);
        chk("rst_stall.adr_err", {31'b0, adr_err}, 32'h0);

        // Wrap-around of sequential fetch
        drive(1'b0, 1'b0, 2'd3, 1'b0); rs_data = 32'hFFFF_FFFC;
        cycle("jr_top");
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        cycle("wrap");
        chk("wrap.F_pc_0", F_pc, 32'h0);
        chk("wrap.D_pc", D_pc, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            r16 = 16'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                  2'($urandom), 1'($urandom));
            imm_ext     = {{16{r16[15]}}, r16};
            instr_index = 26'($urandom);
            rs_data     = {$urandom} & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
